// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan scheduler.
// Optional build macro: SEG_SCAN_PAGE_DP_EN (high-page marker on dp).
package seg_scan_pkg;

    localparam int DIGITS          = 8;
    localparam int DIGITS_PER_PAGE = 4;
    localparam int NIBBLE_W        = 4;
    localparam int BCD_W           = DIGITS * NIBBLE_W;
    localparam int POS_W           = $clog2(DIGITS);

    typedef enum logic {
        PG_LO = 1'b0,
        PG_HI = 1'b1
    } page_state_t;

endpackage

// File: rtl/seg_msd_find.sv
// Combinational priority encoder: position of the highest nonzero BCD nibble
// (0 when the whole value is zero).
module seg_msd_find
    import seg_scan_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [POS_W-1:0] o_msd
);

    logic [DIGITS-1:0] w_nz;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nz
            assign w_nz[gi] = |i_bcd[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    always_comb begin
        o_msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_nz[i]) begin
                o_msd = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display with blanking,
// minus sign and two-page auto paging. Optional macro: SEG_SCAN_PAGE_DP_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 12,
    parameter int PAGE_HOLD = 400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BCD_W-1:0] bcd,
    input  logic             sign,
    input  logic             bcd_valid,
    output logic [3:0]       digit_sel,
    output logic [3:0]       hex_out,
    output logic             blank,
    output logic             minus,
    output logic             page_hi,
    output logic             sign_ovf
`ifdef SEG_SCAN_PAGE_DP_EN
    ,
    output logic             dp
`endif
);

    localparam int CNT_W = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PAGE_HOLD - 1);

    logic [SCAN_DIV-1:0] r_presc;
    logic [1:0]          r_idx;
    logic                r_pend;
    logic [BCD_W-1:0]    r_pend_bcd;
    logic                r_pend_sign;
    logic [BCD_W-1:0]    r_act_bcd;
    logic                r_act_sign;
    page_state_t         r_page;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [3:0]          r_digit_sel;
    logic [3:0]          r_hex;
    logic                r_blank;
    logic                r_minus;
    logic                r_sign_ovf;

    logic                w_tick;
    logic                w_boundary;
    logic                w_load;
    logic [BCD_W-1:0]    w_act_bcd_next;
    logic                w_act_sign_next;
    logic [POS_W-1:0]    w_msd_next;
    logic                w_two_page_next;
    logic [1:0]          w_idx_next;
    page_state_t         w_page_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [POS_W-1:0]    w_pos;
    logic [POS_W:0]      w_msd_plus1;
    logic                w_minus;
    logic                w_blank;
    logic [3:0]          w_hex;
    logic [NIBBLE_W-1:0] w_digits [DIGITS];

    assign w_tick     = &r_presc;
    assign w_boundary = w_tick & (r_idx == 2'd3);
    assign w_load     = w_boundary & (bcd_valid | r_pend);
    assign w_idx_next = w_tick ? r_idx + 2'd1 : r_idx;

    // Everything downstream is computed from the post-edge active value, so the
    // first digit of a frame already reflects a value loaded at that boundary.
    assign w_act_bcd_next  = w_load ? (bcd_valid ? bcd  : r_pend_bcd)  : r_act_bcd;
    assign w_act_sign_next = w_load ? (bcd_valid ? sign : r_pend_sign) : r_act_sign;

    seg_msd_find u_msd_find (
        .i_bcd (w_act_bcd_next),
        .o_msd (w_msd_next)
    );

    assign w_two_page_next = (w_msd_next >= POS_W'(DIGITS_PER_PAGE))
                           | (w_act_sign_next & (w_msd_next == POS_W'(DIGITS_PER_PAGE - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_pend      <= 1'b0;
            r_pend_bcd  <= '0;
            r_pend_sign <= 1'b0;
            r_act_bcd   <= '0;
            r_act_sign  <= 1'b0;
        end else begin
            r_presc    <= r_presc + 1'b1;
            r_idx      <= w_idx_next;
            r_act_bcd  <= w_act_bcd_next;
            r_act_sign <= w_act_sign_next;
            if (w_load) begin
                r_pend <= 1'b0;
            end else if (bcd_valid) begin
                r_pend      <= 1'b1;
                r_pend_bcd  <= bcd;
                r_pend_sign <= sign;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_page      <= PG_LO;
            r_frame_cnt <= '0;
        end else begin
            r_page      <= w_page_next;
            r_frame_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_page_next = r_page;
        w_cnt_next  = r_frame_cnt;
        if (w_load) begin
            w_page_next = w_two_page_next ? PG_HI : PG_LO;
            w_cnt_next  = '0;
        end else if (!w_two_page_next) begin
            w_page_next = PG_LO;
            w_cnt_next  = '0;
        end else if (w_boundary) begin
            if (r_frame_cnt == HOLD_LAST) begin
                w_cnt_next  = '0;
                w_page_next = (r_page == PG_HI) ? PG_LO : PG_HI;
            end else begin
                w_cnt_next = r_frame_cnt + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_digits[gi] = w_act_bcd_next[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign w_pos       = {(w_page_next == PG_HI), w_idx_next};
    assign w_msd_plus1 = {1'b0, w_msd_next} + 1'b1;
    assign w_minus     = w_act_sign_next & ({1'b0, w_pos} == w_msd_plus1)
                       & (w_msd_next != POS_W'(DIGITS - 1));
    assign w_blank     = ~w_minus & (w_pos > w_msd_next) & (w_pos != '0);
    assign w_hex       = (w_minus | w_blank) ? 4'd0 : w_digits[w_pos];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit_sel <= 4'b0001;
            r_hex       <= '0;
            r_blank     <= 1'b0;
            r_minus     <= 1'b0;
            r_sign_ovf  <= 1'b0;
        end else begin
            r_digit_sel <= 4'b0001 << w_idx_next;
            r_hex       <= w_hex;
            r_blank     <= w_blank;
            r_minus     <= w_minus;
            r_sign_ovf  <= w_act_sign_next & (w_msd_next == POS_W'(DIGITS - 1));
        end
    end

    assign digit_sel = r_digit_sel;
    assign hex_out   = r_hex;
    assign blank     = r_blank;
    assign minus     = r_minus;
    assign page_hi   = (r_page == PG_HI);
    assign sign_ovf  = r_sign_ovf;

`ifdef SEG_SCAN_PAGE_DP_EN
    logic r_dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp <= 1'b0;
        end else begin
            r_dp <= (w_page_next == PG_HI) & (w_idx_next == 2'd3);
        end
    end

    assign dp = r_dp;
`endif

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the shared 4-digit multiplexed 7-segment display. It takes the 8-digit BCD result from the binary-to-BCD converter and time-shares the single hex-to-segment decoder between digit positions. It adds leading-zero blanking and a minus sign, and auto-pages between the low and high 4-digit halves when the value needs more than 4 positions. It sits between the BCD converter and the segment decoder / anode drivers in the top level.

Parameters:
SCAN_DIV, 12, prescaler width; one scan tick every 2^SCAN_DIV clocks (~82 us at 50 MHz).
PAGE_HOLD, 400, frames (4 ticks each) a page is held before toggling in two-page mode.

Ports:
clk  in  1  system clock (50 MHz).
rst  in  1  asynchronous, active-high reset.
bcd  in  32  eight BCD digits; [3:0] = units ... [31:28] = ten-millions.
sign  in  1  1 = value negative.
bcd_valid  in  1  one-cycle strobe; bcd/sign are valid this cycle.
digit_sel  out  4  one-hot, active-high digit enable; bit0 = rightmost.
hex_out  out  4  digit value for the segment decoder.
blank  out  1  1 = current digit dark (segments off).
minus  out  1  1 = current digit shows '-' (overrides hex_out/blank).
page_hi  out  1  1 = high half (positions 4..7) currently shown.
sign_ovf  out  1  1 = negative value with no free position for '-'.

Behaviour:
- Reset (async, rst=1): digit_sel=4'b0001, hex_out=0, blank=0, minus=0, page_hi=0, sign_ovf=0. Prescaler, index, frame counter, active and pending registers all cleared. Display shows "0" on units. Deasserting rst mid-frame restarts at idx 0.
- Prescaler: free-running SCAN_DIV-bit counter; tick = all-ones. Index idx 0->1->2->3->0 advances on each tick. Frame boundary = tick while idx==3.
- Capture: bcd_valid loads pending={bcd,sign} and sets pend. At a frame boundary, if bcd_valid or pend, then active <= (bcd_valid ? input : pending) and pend clears. Same-cycle strobe and boundary: the input wins. Latency from strobe to visible: at most 4 ticks + 1 clock. No tearing within a frame.
- msd = highest position with a nonzero digit in active, 0 if all zero. two_page = (msd>=4) | (sign & msd==3).
- Page FSM, states PG_LO / PG_HI:
  - On an active load: state = two_page ? PG_HI : PG_LO; frame counter = 0.
  - Otherwise, when two_page holds, each boundary increments the frame counter. At PAGE_HOLD-1 it wraps to 0 and the state toggles.
  - When two_page is 0, the state stays PG_LO.
  - page_hi = (state==PG_HI).
- Per position p = page_hi*4 + idx:
  - minus = sign & (p == msd+1) & (msd < 7).
  - Otherwise blank = (p > msd) & (p != 0).
  - hex_out = active digit p, or 0 when blank or minus.
  - sign_ovf = sign & (msd==7).
- All outputs registered and updated the clock after the tick, together with digit_sel.
- Digits must never be invalid BCD. Any nibble >9 is passed through unchanged; the decoder handles it.

Optional Feature:
SEG_SCAN_PAGE_DP_EN: adds output dp (1 bit, reset 0). dp=1 while page_hi=1 and idx==3, marking the high page. Without the macro, the port is absent and there is no page marker.

Decomposition:
- Shared package seg_scan_pkg: page state enum (PG_LO, PG_HI), the DIGITS=8 and DIGITS_PER_PAGE=4 constants, and the BCD nibble width.
- One natural sub-module: seg_msd_find, a combinational highest-nonzero-nibble priority encoder (32 bits in, 3-bit msd out).
- Prescaler, capture, page FSM and output mux stay in the top.

Test Plan:
1. Reset release with no strobe, SCAN_DIV=3 -> digit_sel cycles 0001,0010,0100,1000 every 8 clocks; units hex_out=0 blank=0; the other three digits blank=1.
2. bcd=32'h00001234, sign=0 -> after the next boundary, positions 0..3 show 4,3,2,1 with no blanks; page_hi stays 0 indefinitely.
3. bcd=32'h00000042, sign=1 -> p0=2, p1=4, p2 minus=1, p3 blank=1; sign_ovf=0.
4. bcd=32'h00123456, PAGE_HOLD=2 -> first frame page_hi=1 showing 2,1 with p6,p7 blank; after 2 frames page_hi=0 showing 6,5,4,3; the pages then alternate every 2 frames.
5. bcd=32'h87654321, sign=1 -> sign_ovf=1; minus never asserted.
6. Strobes: first strobe mid-frame, a second strobe exactly on the boundary cycle -> the second value becomes active at that boundary. Assert rst mid-frame -> all outputs return to reset values immediately, without waiting for clk.
